// File: rtl/pixel_pkg.sv
// Shared pixel definitions for the gray/colour conversion paths.
// Pixel width, tint fixed-point default, luma weights, mode codes.
package pixel_pkg;

  localparam int PIXEL_W       = 8;
  localparam int FRAC_BITS_DEF = 16;

  localparam logic [15:0] LUMA_R_Q16 = 16'd19595;
  localparam logic [15:0] LUMA_G_Q16 = 16'd38470;
  localparam logic [15:0] LUMA_B_Q16 = 16'd7471;

  typedef enum logic {
    MODE_REPLICATE = 1'b0,
    MODE_TINT      = 1'b1
  } mode_e;

endpackage

// File: rtl/channel_scale.sv
// One colour channel: gray times a Q0.FRAC_BITS weight.
// The product is truncated (never rounded) back to a pixel.
module channel_scale
  import pixel_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic [PIXEL_W-1:0]   gray,
  input  logic [FRAC_BITS-1:0] weight,
  output logic [PIXEL_W-1:0]   y
);

  logic [PIXEL_W+FRAC_BITS-1:0] prod;

  assign prod = gray * weight;
  assign y    = PIXEL_W'(prod >> FRAC_BITS);

endmodule

// File: rtl/gray_to_rgb_stream.sv
// Streaming gray -> RGB expander, 2-stage valid/ready pipe.
// Config is latched per frame and travels with stage 1.
module gray_to_rgb_stream
  import pixel_pkg::*;
#(
  parameter int PIXELS_PER_FRAME = 16,
  parameter int FRAC_BITS        = FRAC_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIXEL_W-1:0]   gray,
  input  logic                 mode,
  input  logic [FRAC_BITS-1:0] tint_r,
  input  logic [FRAC_BITS-1:0] tint_g,
  input  logic [FRAC_BITS-1:0] tint_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIXEL_W-1:0]   R,
  output logic [PIXEL_W-1:0]   G,
  output logic [PIXEL_W-1:0]   B,
  output logic                 last,
  output logic                 done
);

  localparam int CW = $clog2(PIXELS_PER_FRAME);
  localparam logic [CW-1:0] LAST_CNT = CW'(PIXELS_PER_FRAME - 1);

  logic                 stall;
  logic                 acc;
  logic                 frame_start;
  logic [CW-1:0]        cnt;

  mode_e                cfg_mode;
  logic [FRAC_BITS-1:0] cfg_tr, cfg_tg, cfg_tb;
  mode_e                cur_mode;
  logic [FRAC_BITS-1:0] cur_tr, cur_tg, cur_tb;

  logic                 s1_valid;
  logic                 s1_last;
  logic [PIXEL_W-1:0]   s1_gray;
  mode_e                s1_mode;
  logic [FRAC_BITS-1:0] s1_tr, s1_tg, s1_tb;

  logic [PIXEL_W-1:0]   sc_r, sc_g, sc_b;

  assign stall       = out_valid && !out_ready;
  assign in_ready    = !stall;
  assign acc         = in_valid && in_ready;
  assign frame_start = (cnt == '0);

  // Pixel 0 of a frame uses the live inputs, later pixels the latch
  always_comb begin
    cur_mode = cfg_mode;
    cur_tr   = cfg_tr;
    cur_tg   = cfg_tg;
    cur_tb   = cfg_tb;
    if (frame_start) begin
      cur_mode = mode_e'(mode);
      cur_tr   = tint_r;
      cur_tg   = tint_g;
      cur_tb   = tint_b;
    end
  end

  // Capture frame configuration on the first accepted pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_mode <= MODE_REPLICATE;
      cfg_tr   <= '0;
      cfg_tg   <= '0;
      cfg_tb   <= '0;
    end else if (acc && frame_start) begin
      cfg_mode <= mode_e'(mode);
      cfg_tr   <= tint_r;
      cfg_tg   <= tint_g;
      cfg_tb   <= tint_b;
    end
  end

  // Count accepted pixels within the frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (acc) begin
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
    end
  end

  // Stage 1: gray, last flag and the pixel's own config
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_gray  <= '0;
      s1_mode  <= MODE_REPLICATE;
      s1_tr    <= '0;
      s1_tg    <= '0;
      s1_tb    <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= (cnt == LAST_CNT);
        s1_gray <= gray;
        s1_mode <= cur_mode;
        s1_tr   <= cur_tr;
        s1_tg   <= cur_tg;
        s1_tb   <= cur_tb;
      end
    end
  end

  channel_scale #(.FRAC_BITS(FRAC_BITS)) u_sc_r (
    .gray   (s1_gray),
    .weight (s1_tr),
    .y      (sc_r)
  );

  channel_scale #(.FRAC_BITS(FRAC_BITS)) u_sc_g (
    .gray   (s1_gray),
    .weight (s1_tg),
    .y      (sc_g)
  );

  channel_scale #(.FRAC_BITS(FRAC_BITS)) u_sc_b (
    .gray   (s1_gray),
    .weight (s1_tb),
    .y      (sc_b)
  );

  // Stage 2: registered RGB, held while downstream stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      last      <= 1'b0;
      R         <= '0;
      G         <= '0;
      B         <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        last <= s1_last;
        if (s1_mode == MODE_TINT) begin
          R <= sc_r;
          G <= sc_g;
          B <= sc_b;
        end else begin
          R <= s1_gray;
          G <= s1_gray;
          B <= s1_gray;
        end
      end
    end
  end

  // One-cycle pulse after the last pixel leaves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
    end else begin
      done <= out_valid && out_ready && last;
    end
  end

endmodule

// File: tb/tb_gray_to_rgb_stream.sv
// Directed bench for gray_to_rgb_stream.
// Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_gray_to_rgb_stream;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  gray;
  logic        mode;
  logic [15:0] tint_r, tint_g, tint_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  R, G, B;
  logic        last;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic prev_last_hs = 1'b0;
  logic [24:0] got[$];
  logic [24:0] exp_q[$];

  gray_to_rgb_stream #(
    .PIXELS_PER_FRAME (16),
    .FRAC_BITS        (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gray      (gray),
    .mode      (mode),
    .tint_r    (tint_r),
    .tint_g    (tint_g),
    .tint_b    (tint_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .G         (G),
    .B         (B),
    .last      (last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [24:0] px(input int r, input int g,
                                     input int b, input bit l);
    px = {8'(r), 8'(g), 8'(b), l};
  endfunction

  // Collect output handshakes, check done timing
  always @(negedge clk) begin
    if (!reset) begin
      prev_last_hs = 1'b0;
    end else begin
      chk("done", done, prev_last_hs);
      if (done) done_cnt++;
      prev_last_hs = out_valid && out_ready && last;
      if (out_valid && out_ready) got.push_back({R, G, B, last});
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_rgb", {R, G, B}, 24'h0);
    chk("rst_last", last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdy", in_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic push(input logic [7:0] g);
    bit a;
    int n;
    n = 0;
    in_valid = 1'b1;
    gray = g;
    forever begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      if (a) break;
      n++;
      if (n > 100) begin
        chk("push_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_and_compare(input string name);
    int t;
    t = 0;
    while (got.size() < exp_q.size() && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_cnt"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_px%0d", name, i), got[i], exp_q[i]);
  endtask

  logic [23:0] hold;
  int d0;

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    gray = '0;
    mode = 1'b0;
    tint_r = '0;
    tint_g = '0;
    tint_b = '0;
    #12;

    // replicate, latency
    do_reset();
    mode = 1'b0;
    push(8'h80);
    @(negedge clk);
    chk("lat_ov0", out_valid, 1'b0);
    @(negedge clk);
    chk("lat_ov1", out_valid, 1'b1);
    chk("rep_rgb", {R, G, B}, 24'h808080);
    chk("rep_last", last, 1'b0);

    // tint
    do_reset();
    mode = 1'b1;
    tint_r = 16'h8000;
    tint_g = 16'hFFFF;
    tint_b = 16'h0000;
    push(8'd200);
    push(8'd255);
    exp_q.push_back(px(100, 199, 0, 0));
    exp_q.push_back(px(127, 254, 0, 0));
    wait_and_compare("tint");

    // backpressure
    do_reset();
    mode = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) push(8'(i));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        hold = {R, G, B};
        chk("bp_ov", out_valid, 1'b1);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          chk("bp_rdy", in_ready, 1'b0);
          chk("bp_hold", {R, G, B}, hold);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 8; i++) exp_q.push_back(px(i, i, i, 0));
    wait_and_compare("bp");

    // frame boundary, config change mid-frame
    do_reset();
    mode = 1'b0;
    tint_r = 16'h0000;
    tint_g = 16'h0000;
    tint_b = 16'h0000;
    d0 = done_cnt;
    for (int k = 0; k < 32; k++) begin
      if (k == 5) begin
        mode = 1'b1;
        tint_r = 16'h8000;
        tint_g = 16'h4000;
        tint_b = 16'hFFFF;
      end
      push(8'(k * 7));
    end
    for (int k = 0; k < 32; k++) begin
      int g;
      g = k * 7;
      if (k < 16)
        exp_q.push_back(px(g, g, g, k == 15));
      else
        exp_q.push_back(px(g / 2, g / 4, (g > 0) ? g - 1 : 0, k == 31));
    end
    wait_and_compare("frm");
    chk("frm_done", done_cnt - d0, 2);

    // reset mid-frame
    do_reset();
    mode = 1'b0;
    for (int k = 1; k <= 6; k++) push(8'(k));
    reset = 1'b0;
    #1;
    chk("mid_ov", out_valid, 1'b0);
    chk("mid_done", done, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    got.delete();
    exp_q.delete();
    d0 = done_cnt;
    for (int k = 0; k < 16; k++) push(8'(10 + k));
    for (int k = 0; k < 16; k++)
      exp_q.push_back(px(10 + k, 10 + k, 10 + k, k == 15));
    wait_and_compare("mid");
    chk("mid_dcnt", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
